// File: rtl/i2s_tx.sv
// i2s_tx: stereo 16-bit I2S (Philips) transmitter with sample buffering.
//   Bit clock i2s_sck = clk / (2*CLK_DIV). Each frame is 64 bit-slots long:
//   left word in slots 0..15, right word in slots 32..47, zero padding elsewhere.
//   Word select and data change on the falling edges of i2s_sck.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   in_valid/in_ready   sample handshake (in_ready is combinational from registers)
//   in_left, in_right   signed 16-bit samples
//   i2s_sck/ws/sd       I2S bit clock, word select (0=left), serial data MSB first
//   frame_start         one-clk pulse per frame load
//   underrun            one-clk pulse when a frame loads from an empty buffer in RUN
// Configuration:
//   I2S_TX_FIFO_EN      defined: 4-entry stereo FIFO; undefined: single holding register
module i2s_tx #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_left,
  input  logic [15:0] in_right,
  output logic        i2s_sck,
  output logic        i2s_ws,
  output logic        i2s_sd,
  output logic        frame_start,
  output logic        underrun
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        sck_q, sck_d;
  logic [5:0]  bc_q, bc_d;
  logic        ws_q, ws_d;
  logic        sd_q, sd_d;
  logic [15:0] frm_l_q, frm_l_d;
  logic [15:0] frm_r_q, frm_r_d;
  logic        frame_start_q, frame_start_d;
  logic        underrun_q, underrun_d;

  logic        tick, fall, load;
  logic        push, pop;
  logic        buf_full, buf_empty;
  logic [15:0] head_l, head_r;
  logic [3:0]  bit_idx;

  // Sample buffer: provides head/full/empty, consumes push/pop.
`ifdef I2S_TX_FIFO_EN
  localparam int unsigned DEPTH = 4;

  logic [15:0] mem_l_q [DEPTH];
  logic [15:0] mem_l_d [DEPTH];
  logic [15:0] mem_r_q [DEPTH];
  logic [15:0] mem_r_d [DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;

  assign buf_full  = (count_q == 3'(DEPTH));
  assign buf_empty = (count_q == 3'd0);
  assign head_l    = mem_l_q[rd_ptr_q];
  assign head_r    = mem_r_q[rd_ptr_q];

  always_comb begin
    mem_l_d  = mem_l_q;
    mem_r_d  = mem_r_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_l_d[wr_ptr_q] = in_left;
      mem_r_d[wr_ptr_q] = in_right;
      wr_ptr_d          = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (!push && pop) count_d = count_q - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_l_q <= mem_l_d;
    mem_r_q <= mem_r_d;
  end
`else
  logic        hold_v_q, hold_v_d;
  logic [15:0] hold_l_q, hold_l_d;
  logic [15:0] hold_r_q, hold_r_d;

  assign buf_full  = hold_v_q;
  assign buf_empty = !hold_v_q;
  assign head_l    = hold_l_q;
  assign head_r    = hold_r_q;

  // Push only happens when empty, so push and pop never coincide here.
  always_comb begin
    hold_v_d = hold_v_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (push) begin
      hold_v_d = 1'b1;
      hold_l_d = in_left;
      hold_r_d = in_right;
    end else if (pop) begin
      hold_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_v_q <= 1'b0;
    else     hold_v_q <= hold_v_d;
  end

  always_ff @(posedge clk) begin
    hold_l_q <= hold_l_d;
    hold_r_q <= hold_r_d;
  end
`endif

  assign in_ready = !buf_full;
  assign push     = in_valid && in_ready;

  // Divider tick, sck falling edge, and frame load at the 63 -> 0 wrap.
  assign tick = (div_q == DIV_LAST);
  assign fall = tick && sck_q;
  assign load = fall && (bc_q == 6'd63);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: leave IDLE on the first accepted sample.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && push) state_d = RUN;
  end

  // FSM outputs: buffer pop and frame pulses at each load.
  always_comb begin
    pop           = load && !buf_empty;
    frame_start_d = load;
    underrun_d    = load && buf_empty && (state_q == RUN);
  end

  // Bit clock, bit counter and serializer.
  always_comb begin
    div_d   = tick ? 8'd0 : div_q + 8'd1;
    sck_d   = tick ? !sck_q : sck_q;
    bc_d    = fall ? bc_q + 6'd1 : bc_q;
    frm_l_d = frm_l_q;
    frm_r_d = frm_r_q;
    ws_d    = ws_q;
    sd_d    = sd_q;
    if (load) begin
      frm_l_d = pop ? head_l : 16'd0;
      frm_r_d = pop ? head_r : 16'd0;
    end
    // Slot 15-bc (left) and 47-bc (right) both reduce to ~bc[3:0].
    bit_idx = ~bc_d[3:0];
    if (fall) begin
      ws_d = (bc_d >= 6'd31) && (bc_d <= 6'd62);
      if (bc_d[4])      sd_d = 1'b0;
      else if (bc_d[5]) sd_d = frm_r_d[bit_idx];
      else              sd_d = frm_l_d[bit_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= 8'd0;
      sck_q         <= 1'b0;
      bc_q          <= 6'd63;
      ws_q          <= 1'b0;
      sd_q          <= 1'b0;
      frm_l_q       <= 16'd0;
      frm_r_q       <= 16'd0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      div_q         <= div_d;
      sck_q         <= sck_d;
      bc_q          <= bc_d;
      ws_q          <= ws_d;
      sd_q          <= sd_d;
      frm_l_q       <= frm_l_d;
      frm_r_q       <= frm_r_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign i2s_sck     = sck_q;
  assign i2s_ws      = ws_q;
  assign i2s_sd      = sd_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule
